// File: rtl/if_stage_fetch.sv
`default_nettype none
// ============================================================================
// Module      : if_stage_fetch
// Description : Instruction-fetch stage of the 5-stage MIPS pipeline. Owns
//               the program counter, drives the instruction-memory address,
//               and captures the fetched word into the IF/ID register.
//               Honours hazard stalls, branch/jump redirects and flushes.
// Revision    : 1.0 - initial release
// ============================================================================
module if_stage_fetch #(
    parameter int unsigned RESET_ALIGN = 1,
    parameter logic [31:0] NOP_WORD    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_init,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] program_counter,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic        misalign_err,
    output logic [31:0] fetch_count
);

    localparam logic [31:0] c_PC_STEP = 32'd4;

    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_pc4;
    logic        r_valid;
    logic        r_misalign;
    logic [31:0] r_count;

    logic [31:0] w_pc_init_al;
    logic [31:0] w_redirect_al;
    logic [31:0] w_pc_plus4;
    logic        w_squash;
    logic        w_load;
    logic        w_unaligned;

    // Alignment of externally supplied addresses, PC increment and IF/ID control decode
    always_comb begin
        w_pc_init_al  = pc_init;
        w_redirect_al = redirect_pc;
        if (RESET_ALIGN != 0) begin
            w_pc_init_al  = {pc_init[31:2], 2'b00};
            w_redirect_al = {redirect_pc[31:2], 2'b00};
        end
        // Plain 32-bit add: wrap from 32'hFFFFFFFC to 0 is intended, not an error
        w_pc_plus4  = r_pc + c_PC_STEP;
        // A redirect means the word currently on imem_rdata is wrong-path
        w_squash    = flush | redirect;
        w_load      = ~w_squash & ~stall;
        // Misalignment is reported from the raw target, independent of RESET_ALIGN
        w_unaligned = redirect & (redirect_pc[1:0] != 2'b00);
    end

    // Program counter: reset > redirect > stall > sequential
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= w_pc_init_al;
        end else if (redirect) begin
            r_pc <= w_redirect_al;
        end else if (!stall) begin
            r_pc <= w_pc_plus4;
        end
    end

    // IF/ID register and fetch counter: reset > flush/redirect > stall > load
    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr <= NOP_WORD;
            r_pc4   <= 32'd0;
            r_valid <= 1'b0;
            r_count <= 32'd0;
        end else if (w_squash) begin
            r_instr <= NOP_WORD;
            r_pc4   <= 32'd0;
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_instr <= imem_rdata;
            r_pc4   <= w_pc_plus4;
            r_valid <= 1'b1;
            r_count <= r_count + 32'd1;
        end
    end

    // Sticky misaligned-redirect flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_misalign <= 1'b0;
        end else if (w_unaligned) begin
            r_misalign <= 1'b1;
        end
    end

    assign imem_addr       = r_pc;
    assign program_counter = r_pc;
    assign if_id_instr     = r_instr;
    assign if_id_pc4       = r_pc4;
    assign if_id_valid     = r_valid;
    assign misalign_err    = r_misalign;
    assign fetch_count     = r_count;

endmodule
`default_nettype wire
